axi_wr_slave_if: RTL and testbench
==================================

Name: axi_wr_slave_if

Overview:
- Slave-side AXI write front end for a word-addressed SRAM-style memory (IM/DM class), one AXI slave port.
- Accepts one write burst at a time on the AW/W channels and drives per-byte memory write strobes.
- Generates the B response that the interconnect's write-response router forwards back to the originating master.
- The returned BID carries the full extended slave-side ID, master bits included.

Parameters:
- IDS_W, 8, slave-side ID width (4 master-select bits + 4 ID bits).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, data width; fixed at 32, WSTRB is 4 bits.
- MEM_AW, 14, memory word-address width; region is 2^(MEM_AW+2) bytes.
- BASE_ADDR, 32'h0001_0000, region base; must be aligned to the region size.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- AWID  in  IDS_W  write address ID.
- AWADDR  in  ADDR_W  burst start byte address.
- AWLEN  in  4  beats-1.
- AWSIZE  in  3  beat size; only 3'b010 is legal.
- AWBURST  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  4  byte strobes.
- WLAST  in  1  last beat.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BID  out  IDS_W  response ID.
- BRESP  out  2  response code: 00 OKAY, 10 SLVERR.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- mem_addr  out  MEM_AW  word address.
- mem_wdata  out  DATA_W  write data.
- mem_we  out  4  per-byte write enable, active-high.

Behaviour:
- FSM states: IDLE, DATA, RESP. Reset puts the FSM in IDLE.
- Reset values: AWREADY=1, WREADY=0, BVALID=0, BID=0, BRESP=00, mem_we=0, internal address, beat count and error flag all 0.
- AWREADY=(state==IDLE); WREADY=(state==DATA); BVALID=(state==RESP).
- IDLE, on AWVALID&AWREADY:
  - Capture AWID, AWADDR[MEM_AW+1:2], AWLEN, AWBURST.
  - Clear the beat counter.
  - Set err if any of: AWADDR upper bits [ADDR_W-1:MEM_AW+2] differ from BASE_ADDR's; AWSIZE!=3'b010; AWBURST==2'b11; or AWBURST is WRAP with an illegal length (see Optional Feature).
  - Next state DATA.
- DATA, per W handshake (WVALID&WREADY):
  - mem_we=WSTRB when err=0, else 4'b0000. Combinational, same cycle as the handshake; the memory samples at the next edge.
  - mem_addr=current word address; mem_wdata=WDATA.
  - mem_we=0 in every cycle without a W handshake.
  - Address update after the beat: FIXED holds; INCR adds 1, wrapping modulo 2^MEM_AW; WRAP per the Optional Feature.
  - Beat counter increments.
- DATA termination:
  - Beat with count==AWLEN: leave for RESP. If WLAST=0 on that beat, set err.
  - Beat with WLAST=1 and count<AWLEN: set err, leave for RESP, perform no further writes.
  - Any extra W beats after termination are not accepted: WREADY stays 0 until the next burst's DATA state.
- RESP:
  - BID=captured ID; BRESP=err?2'b10:2'b00.
  - BVALID and BID/BRESP are held stable until BREADY.
  - On BVALID&BREADY: go to IDLE, clear err. AWREADY returns the following cycle, so there is at least one bubble between bursts.
- AWVALID during DATA/RESP is ignored; AWREADY stays 0.
- Reset asserted mid-burst: immediate return to reset values; the partial burst is abandoned with no B response; mem_we drops asynchronously.
- No outstanding transactions; one burst in flight at a time.

Optional Feature:
- Macro: AXI_WR_SLAVE_WRAP_EN.
- Defined:
  - WRAP bursts are legal only with AWLEN in {1,3,7,15}; any other AWLEN gives err=1.
  - Boundary = AWLEN+1 words. The low log2(AWLEN+1) bits of the word address increment and wrap; upper bits hold.
- Undefined:
  - Any AWBURST=WRAP sets err=1.
  - Such a burst is still fully consumed through the WLAST/AWLEN rules, with no memory writes, and answered SLVERR.

Test Plan:
- Single beat, OKAY: AWADDR=0x0001_0010, AWLEN=0, AWID=0x21, WSTRB=4'hF, WDATA=0xDEADBEEF, WLAST=1 -> mem_addr=4, mem_we=4'hF in the handshake cycle; then BID=0x21, BRESP=00, BVALID held until BREADY.
- INCR burst with backpressure: AWADDR=0x0001_0000, AWLEN=3, WVALID gaps, BREADY=0 for 5 cycles -> mem_addr 0,1,2,3, one write per handshake; BVALID stable for 5 cycles; AWREADY=1 the cycle after the B handshake.
- Out-of-region address: AWADDR=0x0002_0000, AWLEN=1 -> two W beats accepted, mem_we=0 throughout, BRESP=10.
- Early WLAST: AWLEN=3 with WLAST=1 on beat 1 -> two writes, WREADY=0 afterwards, BRESP=10. Then a normal burst -> BRESP=00, confirming err was cleared.
- WRAP burst: AWADDR=0x0001_0018, AWLEN=3, AWBURST=10 -> with AXI_WR_SLAVE_WRAP_EN: mem_addr 6,7,4,5, BRESP=00; without it: no writes, BRESP=10.
- Reset mid-burst: rst=1 after beat 1 of an AWLEN=3 burst -> mem_we=0 and BVALID=0 immediately, AWREADY=1; a new burst after release completes with BRESP=00.

Source files
------------

// File: rtl/axi_wr_slave_if_if.sv
// AXI write-channel bundle (AW, W, B) between an interconnect-side master
// and the axi_wr_slave_if memory front end.
interface axi_wr_slave_if_if #(
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [IDS_W-1:0]  AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [3:0]        WSTRB;
    logic              WLAST;
    logic              WVALID;
    logic              WREADY;
    logic [IDS_W-1:0]  BID;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID,
        input  BREADY,
        output AWREADY, WREADY, BID, BRESP, BVALID
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID,
        output BREADY,
        input  AWREADY, WREADY, BID, BRESP, BVALID
    );
endinterface

// File: rtl/axi_wr_slave_if.sv
// Slave-side AXI write front end for a word-addressed SRAM region.
// Accepts one burst at a time, turns each W beat into per-byte memory write
// strobes and answers with a B response carrying the full extended ID.
// Optional macro AXI_WR_SLAVE_WRAP_EN enables WRAP bursts (AWLEN 1/3/7/15);
// without it every WRAP burst is consumed without writes and answered SLVERR.
module axi_wr_slave_if #(
    parameter int                IDS_W     = 8,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MEM_AW    = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_wr_slave_if_if.slave     s,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    output logic [3:0]           mem_we
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDS_W-1:0]   id_q, id_d;
    logic [MEM_AW-1:0]  addr_q, addr_d;
    logic [3:0]         len_q, len_d;
    logic [1:0]         burst_q, burst_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               aw_hs;
    logic               w_hs;
    logic               aw_bad;
    logic [MEM_AW-1:0]  addr_next;
    logic [1:0]         unused_addr_lsb;

    // Byte offset within a word is irrelevant to a word-addressed memory.
    assign unused_addr_lsb = s.AWADDR[1:0];

    assign s.AWREADY = (state_q == IDLE);
    assign s.WREADY  = (state_q == DATA);
    assign s.BVALID  = (state_q == RESP);
    assign s.BID     = (state_q == RESP) ? id_q : '0;
    assign s.BRESP   = (state_q == RESP && err_q) ? 2'b10 : 2'b00;

    assign aw_hs = s.AWVALID && (state_q == IDLE);
    assign w_hs  = s.WVALID && (state_q == DATA);

    assign mem_addr  = addr_q;
    assign mem_wdata = s.WDATA;

    // Judge an incoming AW request: wrong region, size, reserved burst type or
    // an unsupported wrap all make the whole burst an error burst.
    always_comb begin
        aw_bad = 1'b0;
        if (s.AWADDR[ADDR_W-1:MEM_AW+2] != BASE_ADDR[ADDR_W-1:MEM_AW+2]) begin
            aw_bad = 1'b1;
        end
        if (s.AWSIZE != 3'b010) begin
            aw_bad = 1'b1;
        end
        if (s.AWBURST == 2'b11) begin
            aw_bad = 1'b1;
        end
`ifdef AXI_WR_SLAVE_WRAP_EN
        if (s.AWBURST == 2'b10 &&
            !(s.AWLEN == 4'd1 || s.AWLEN == 4'd3 ||
              s.AWLEN == 4'd7 || s.AWLEN == 4'd15)) begin
            aw_bad = 1'b1;
        end
`else
        if (s.AWBURST == 2'b10) begin
            aw_bad = 1'b1;
        end
`endif
    end

    // Word address for the beat after this one, following the burst type.
    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            2'b01:   addr_next = addr_q + MEM_AW'(1);
`ifdef AXI_WR_SLAVE_WRAP_EN
            2'b10:   addr_next = (addr_q & ~{{(MEM_AW-4){1'b0}}, len_q}) |
                                 ((addr_q + MEM_AW'(1)) & {{(MEM_AW-4){1'b0}}, len_q});
`endif
            default: addr_next = addr_q;
        endcase
    end

    // Burst sequencing: capture AW, issue one write per W beat, then respond.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mem_we  = 4'b0000;

        case (state_q)
            IDLE: begin
                if (aw_hs) begin
                    id_d    = s.AWID;
                    addr_d  = s.AWADDR[MEM_AW+1:2];
                    len_d   = s.AWLEN;
                    burst_d = s.AWBURST;
                    cnt_d   = 4'd0;
                    err_d   = aw_bad;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_hs) begin
                    mem_we = err_q ? 4'b0000 : s.WSTRB;
                    addr_d = addr_next;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == len_q) begin
                        if (!s.WLAST) begin
                            err_d = 1'b1;
                        end
                        state_d = RESP;
                    end else if (s.WLAST) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (s.BREADY) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and burst context registers; reset abandons any burst in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_slave_if.sv
// Directed bench for axi_wr_slave_if: single beats, INCR bursts with
// backpressure, error bursts, early WLAST, WRAP and reset mid-burst.
module tb_axi_wr_slave_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic        rdy;
    int          vectors = 0;
    int          miscompares = 0;

    axi_wr_slave_if_if #(.IDS_W(8), .ADDR_W(32), .DATA_W(32)) bus ();

    axi_wr_slave_if dut (
        .clk       (clk),
        .rst       (rst),
        .s         (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we)
    );

    always #5 clk = ~clk;

    // Present an AW request for one cycle and report the sampled AWREADY.
    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input logic [2:0] size, output logic ready);
        @(negedge clk);
        bus.AWID    = id;
        bus.AWADDR  = addr;
        bus.AWLEN   = len;
        bus.AWBURST = burst;
        bus.AWSIZE  = size;
        bus.AWVALID = 1'b1;
        #1 ready = bus.AWREADY;
        @(posedge clk);
        #1 bus.AWVALID = 1'b0;
    endtask

    // Drive one W cycle (valid or gap) and settle just after the falling edge.
    task automatic w_beat(input logic v, input logic [31:0] d,
                          input logic [3:0] st, input logic last);
        @(negedge clk);
        bus.WVALID = v;
        bus.WDATA  = d;
        bus.WSTRB  = st;
        bus.WLAST  = last;
        #1;
    endtask

    // Drive one response-phase cycle with the given BREADY.
    task automatic b_cycle(input logic ready);
        @(negedge clk);
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        bus.BREADY = ready;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.AWVALID = 1'b0; bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0;
        bus.AWSIZE = 3'b010; bus.AWBURST = 2'b01;
        bus.WVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
        bus.BREADY = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (bus.AWREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_awready: got %b want 1", bus.AWREADY); end
        vectors++; if (bus.WREADY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wready: got %b want 0", bus.WREADY); end
        vectors++; if (bus.BVALID !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bvalid: got %b want 0", bus.BVALID); end
        vectors++; if (bus.BID !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_bid: got %h want 00", bus.BID); end
        vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_bresp: got %b want 00", bus.BRESP); end
        vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %h want 0", mem_we); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        send_aw(8'h21, 32'h0001_0010, 4'd0, 2'b01, 3'b010, rdy);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL single_awready: got %b want 1", rdy); end
        w_beat(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
        vectors++; if (bus.WREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL single_wready: got %b want 1", bus.WREADY); end
        vectors++; if (mem_addr !== 14'd4) begin miscompares++; $display("[TB] FAIL single_addr: got %0d want 4", mem_addr); end
        vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL single_we: got %h want f", mem_we); end
        vectors++; if (mem_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL single_wdata: got %h want deadbeef", mem_wdata); end
        b_cycle(1'b0);
        vectors++; if (bus.BVALID !== 1'b1) begin miscompares++; $display("[TB] FAIL single_bvalid: got %b want 1", bus.BVALID); end
        vectors++; if (bus.BID !== 8'h21) begin miscompares++; $display("[TB] FAIL single_bid: got %h want 21", bus.BID); end
        vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL single_bresp: got %b want 00", bus.BRESP); end
        vectors++; if (bus.WREADY !== 1'b0) begin miscompares++; $display("[TB] FAIL single_wready_resp: got %b want 0", bus.WREADY); end
        b_cycle(1'b0);
        vectors++; if (bus.BVALID !== 1'b1) begin miscompares++; $display("[TB] FAIL single_bvalid_hold: got %b want 1", bus.BVALID); end
        b_cycle(1'b1);
        b_cycle(1'b0);
        vectors++; if (bus.BVALID !== 1'b0) begin miscompares++; $display("[TB] FAIL single_bvalid_done: got %b want 0", bus.BVALID); end
        vectors++; if (bus.AWREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL single_awready_back: got %b want 1", bus.AWREADY); end
    endtask

    task automatic test_incr_backpressure();
        logic [6:0] vpat;
        logic [3:0] strbs [4];
        int beat;
        vpat = 7'b1100101;
        strbs = '{4'hF, 4'h3, 4'hC, 4'h1};
        beat = 0;
        send_aw(8'h35, 32'h0001_0000, 4'd3, 2'b01, 3'b010, rdy);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL incr_awready: got %b want 1", rdy); end
        bus.AWID = 8'hEE;
        bus.AWVALID = 1'b1;
        for (int i = 0; i < 7; i++) begin
            w_beat(vpat[i], 32'hA000_0000 + beat, strbs[beat % 4], vpat[i] && (beat == 3));
            vectors++; if (bus.WREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL incr_wready cyc%0d: got %b want 1", i, bus.WREADY); end
            vectors++; if (bus.AWREADY !== 1'b0) begin miscompares++; $display("[TB] FAIL incr_aw_ignored cyc%0d: got %b want 0", i, bus.AWREADY); end
            if (vpat[i]) begin
                vectors++; if (mem_addr !== 14'(beat)) begin miscompares++; $display("[TB] FAIL incr_addr beat%0d: got %0d want %0d", beat, mem_addr, beat); end
                vectors++; if (mem_we !== strbs[beat % 4]) begin miscompares++; $display("[TB] FAIL incr_we beat%0d: got %h want %h", beat, mem_we, strbs[beat % 4]); end
                beat++;
            end else begin
                vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL incr_gap_we cyc%0d: got %h want 0", i, mem_we); end
            end
        end
        bus.AWVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b_cycle(1'b0);
            vectors++; if (bus.BVALID !== 1'b1) begin miscompares++; $display("[TB] FAIL incr_bvalid_hold cyc%0d: got %b want 1", i, bus.BVALID); end
            vectors++; if (bus.BID !== 8'h35) begin miscompares++; $display("[TB] FAIL incr_bid cyc%0d: got %h want 35", i, bus.BID); end
            vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL incr_bresp cyc%0d: got %b want 00", i, bus.BRESP); end
        end
        b_cycle(1'b1);
        b_cycle(1'b0);
        vectors++; if (bus.AWREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL incr_awready_after_b: got %b want 1", bus.AWREADY); end
        vectors++; if (bus.BVALID !== 1'b0) begin miscompares++; $display("[TB] FAIL incr_bvalid_after_b: got %b want 0", bus.BVALID); end
    endtask

    task automatic test_incr_rollover();
        logic [13:0] exp_addr [2];
        exp_addr = '{14'h3FFF, 14'h0000};
        send_aw(8'h12, 32'h0001_FFFC, 4'd1, 2'b01, 3'b010, rdy);
        for (int k = 0; k < 2; k++) begin
            w_beat(1'b1, 32'h1234_0000 + k, 4'hF, k == 1);
            vectors++; if (mem_addr !== exp_addr[k]) begin miscompares++; $display("[TB] FAIL rollover_addr beat%0d: got %h want %h", k, mem_addr, exp_addr[k]); end
            vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL rollover_we beat%0d: got %h want f", k, mem_we); end
        end
        b_cycle(1'b0);
        vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL rollover_bresp: got %b want 00", bus.BRESP); end
        b_cycle(1'b1);
    endtask

    task automatic test_out_of_region();
        send_aw(8'h44, 32'h0002_0000, 4'd1, 2'b01, 3'b010, rdy);
        for (int k = 0; k < 2; k++) begin
            w_beat(1'b1, 32'h5555_0000 + k, 4'hF, k == 1);
            vectors++; if (bus.WREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_wready beat%0d: got %b want 1", k, bus.WREADY); end
            vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL oor_we beat%0d: got %h want 0", k, mem_we); end
        end
        b_cycle(1'b0);
        vectors++; if (bus.BVALID !== 1'b1) begin miscompares++; $display("[TB] FAIL oor_bvalid: got %b want 1", bus.BVALID); end
        vectors++; if (bus.BID !== 8'h44) begin miscompares++; $display("[TB] FAIL oor_bid: got %h want 44", bus.BID); end
        vectors++; if (bus.BRESP !== 2'b10) begin miscompares++; $display("[TB] FAIL oor_bresp: got %b want 10", bus.BRESP); end
        b_cycle(1'b1);
    endtask

    task automatic test_illegal_ctrl();
        logic [2:0] sizes [2];
        logic [1:0] bursts [2];
        sizes  = '{3'b000, 3'b010};
        bursts = '{2'b01, 2'b11};
        for (int c = 0; c < 2; c++) begin
            send_aw(8'h50 + 8'(c), 32'h0001_0100, 4'd0, bursts[c], sizes[c], rdy);
            w_beat(1'b1, 32'h0BAD_0000, 4'hF, 1'b1);
            vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL illegal_we case%0d: got %h want 0", c, mem_we); end
            b_cycle(1'b0);
            vectors++; if (bus.BRESP !== 2'b10) begin miscompares++; $display("[TB] FAIL illegal_bresp case%0d: got %b want 10", c, bus.BRESP); end
            b_cycle(1'b1);
        end
    endtask

    task automatic test_early_wlast();
        send_aw(8'h56, 32'h0001_0040, 4'd3, 2'b01, 3'b010, rdy);
        for (int k = 0; k < 2; k++) begin
            w_beat(1'b1, 32'hE000_0000 + k, 4'hF, k == 1);
            vectors++; if (mem_addr !== 14'(16 + k)) begin miscompares++; $display("[TB] FAIL early_addr beat%0d: got %0d want %0d", k, mem_addr, 16 + k); end
            vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL early_we beat%0d: got %h want f", k, mem_we); end
        end
        w_beat(1'b1, 32'hE000_0002, 4'hF, 1'b0);
        vectors++; if (bus.WREADY !== 1'b0) begin miscompares++; $display("[TB] FAIL early_extra_wready: got %b want 0", bus.WREADY); end
        vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL early_extra_we: got %h want 0", mem_we); end
        vectors++; if (bus.BRESP !== 2'b10) begin miscompares++; $display("[TB] FAIL early_bresp: got %b want 10", bus.BRESP); end
        b_cycle(1'b1);
        send_aw(8'h57, 32'h0001_0004, 4'd0, 2'b01, 3'b010, rdy);
        w_beat(1'b1, 32'hC1EA_0001, 4'hF, 1'b1);
        vectors++; if (mem_addr !== 14'd1) begin miscompares++; $display("[TB] FAIL early_next_addr: got %0d want 1", mem_addr); end
        vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL early_next_we: got %h want f", mem_we); end
        b_cycle(1'b0);
        vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL early_next_bresp: got %b want 00", bus.BRESP); end
        b_cycle(1'b1);
    endtask

    task automatic test_wrap();
        logic [13:0] wrap_addr [4];
        logic [3:0]  exp_we;
        logic [1:0]  exp_resp;
        wrap_addr = '{14'd6, 14'd7, 14'd4, 14'd5};
`ifdef AXI_WR_SLAVE_WRAP_EN
        exp_we   = 4'hF;
        exp_resp = 2'b00;
`else
        exp_we   = 4'h0;
        exp_resp = 2'b10;
`endif
        send_aw(8'h63, 32'h0001_0018, 4'd3, 2'b10, 3'b010, rdy);
        for (int k = 0; k < 4; k++) begin
            w_beat(1'b1, 32'h7700_0000 + k, 4'hF, k == 3);
            vectors++; if (bus.WREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_wready beat%0d: got %b want 1", k, bus.WREADY); end
            vectors++; if (mem_we !== exp_we) begin miscompares++; $display("[TB] FAIL wrap_we beat%0d: got %h want %h", k, mem_we, exp_we); end
`ifdef AXI_WR_SLAVE_WRAP_EN
            vectors++; if (mem_addr !== wrap_addr[k]) begin miscompares++; $display("[TB] FAIL wrap_addr beat%0d: got %0d want %0d", k, mem_addr, wrap_addr[k]); end
`endif
        end
        b_cycle(1'b0);
        vectors++; if (bus.BRESP !== exp_resp) begin miscompares++; $display("[TB] FAIL wrap_bresp: got %b want %b", bus.BRESP, exp_resp); end
        b_cycle(1'b1);
        send_aw(8'h64, 32'h0001_0018, 4'd2, 2'b10, 3'b010, rdy);
        for (int k = 0; k < 3; k++) begin
            w_beat(1'b1, 32'h7800_0000 + k, 4'hF, k == 2);
            vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL wrap_badlen_we beat%0d: got %h want 0", k, mem_we); end
        end
        b_cycle(1'b0);
        vectors++; if (bus.BRESP !== 2'b10) begin miscompares++; $display("[TB] FAIL wrap_badlen_bresp: got %b want 10", bus.BRESP); end
        b_cycle(1'b1);
    endtask

    task automatic test_reset_mid_burst();
        send_aw(8'h70, 32'h0001_0020, 4'd3, 2'b01, 3'b010, rdy);
        for (int k = 0; k < 2; k++) begin
            w_beat(1'b1, 32'h9900_0000 + k, 4'hF, 1'b0);
            vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL rstmid_we beat%0d: got %h want f", k, mem_we); end
        end
        w_beat(1'b1, 32'h9900_0002, 4'hF, 1'b0);
        vectors++; if (mem_we !== 4'hF) begin miscompares++; $display("[TB] FAIL rstmid_we_before: got %h want f", mem_we); end
        rst = 1'b1;
        #1;
        vectors++; if (mem_we !== 4'h0) begin miscompares++; $display("[TB] FAIL rstmid_we_async: got %h want 0", mem_we); end
        vectors++; if (bus.BVALID !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_bvalid: got %b want 0", bus.BVALID); end
        vectors++; if (bus.AWREADY !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_awready: got %b want 1", bus.AWREADY); end
        vectors++; if (bus.WREADY !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_wready: got %b want 0", bus.WREADY); end
        @(negedge clk);
        bus.WVALID = 1'b0;
        rst = 1'b0;
        send_aw(8'h71, 32'h0001_000C, 4'd0, 2'b01, 3'b010, rdy);
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_new_awready: got %b want 1", rdy); end
        w_beat(1'b1, 32'h1357_9BDF, 4'h6, 1'b1);
        vectors++; if (mem_addr !== 14'd3) begin miscompares++; $display("[TB] FAIL rstmid_new_addr: got %0d want 3", mem_addr); end
        vectors++; if (mem_we !== 4'h6) begin miscompares++; $display("[TB] FAIL rstmid_new_we: got %h want 6", mem_we); end
        b_cycle(1'b0);
        vectors++; if (bus.BID !== 8'h71) begin miscompares++; $display("[TB] FAIL rstmid_new_bid: got %h want 71", bus.BID); end
        vectors++; if (bus.BRESP !== 2'b00) begin miscompares++; $display("[TB] FAIL rstmid_new_bresp: got %b want 00", bus.BRESP); end
        b_cycle(1'b1);
        b_cycle(1'b0);
    endtask

    // Run every scenario in order and report.
    initial begin
        test_reset();
        test_single_beat();
        test_incr_backpressure();
        test_incr_rollover();
        test_out_of_region();
        test_illegal_ctrl();
        test_early_wlast();
        test_wrap();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
